// File: rtl/ntt_pkg.sv
`default_nettype none
// ntt_pkg: default transform geometry, address type and sequencer state encoding
// shared by the NTT stage scheduler and its write-back delay line.
package ntt_pkg;

  localparam int N_DEF      = 256;
  localparam int LOGN_DEF   = 8;
  localparam int BU_LAT_DEF = 2;

  typedef logic [LOGN_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ntt_wr_delay.sv
`default_nettype none
// ntt_wr_delay: fixed-depth shift register that carries {valid, addr_a, addr_b}
// from read issue to butterfly write-back; cleared on reset.
module ntt_wr_delay #(
  parameter int LAT = 2,
  parameter int W   = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[LAT-1];

endmodule
`default_nettype wire

// File: rtl/ntt_stage_sched.sv
`default_nettype none
// ntt_stage_sched: issues one radix-2 Cooley-Tukey butterfly per cycle (read pair,
// twiddle index, delayed write-back pair) and drains the BU between stages.
module ntt_stage_sched
  import ntt_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int LOGN   = LOGN_DEF,
  parameter int BU_LAT = BU_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_valid,
  output logic [LOGN-1:0]          rd_addr_a,
  output logic [LOGN-1:0]          rd_addr_b,
  output logic [LOGN-1:0]          tf_addr,
  output logic                     wr_valid,
  output logic [LOGN-1:0]          wr_addr_a,
  output logic [LOGN-1:0]          wr_addr_b,
  output logic [$clog2(LOGN)-1:0]  stage
);

  localparam int SW = $clog2(LOGN);
  localparam int DW = $clog2(BU_LAT + 1);

  state_t          state, state_nxt;
  logic [LOGN-1:0] len;
  logic [LOGN-1:0] k;
  logic [LOGN-1:0] tf;
  logic [LOGN:0]   grp;
  logic [LOGN:0]   grp_nxt;
  logic [DW-1:0]   dcnt;

  logic issue;
  logic last_in_grp;
  logic last_pair;
  logic drain_end;
  logic last_stage;

  assign issue       = (state == ISSUE) && !stall;
  assign last_in_grp = (k == len - LOGN'(1));
  // One extra bit lets the final group boundary reach exactly N without wrapping.
  assign grp_nxt     = grp + {len, 1'b0};
  assign last_pair   = last_in_grp && (grp_nxt == (LOGN+1)'(N));
  assign drain_end   = (dcnt == DW'(BU_LAT - 1));
  assign last_stage  = (len == LOGN'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    rd_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_valid = !stall;
        if (issue && last_pair) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_end) state_nxt = last_stage ? DONE : ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len   <= LOGN'(N / 2);
      grp   <= '0;
      k     <= '0;
      tf    <= LOGN'(1);
      dcnt  <= '0;
      stage <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len   <= LOGN'(N / 2);
            grp   <= '0;
            k     <= '0;
            tf    <= LOGN'(1);
            dcnt  <= '0;
            stage <= '0;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (last_in_grp) begin
              k   <= '0;
              grp <= grp_nxt;
              tf  <= tf + LOGN'(1);
            end else begin
              k <= k + LOGN'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_end) begin
            dcnt <= '0;
            if (!last_stage) begin
              len   <= len >> 1;
              grp   <= '0;
              stage <= stage + SW'(1);
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Addresses are forced to zero whenever no butterfly is issued.
  assign rd_addr_a = rd_valid ? (grp[LOGN-1:0] + k) : '0;
  assign rd_addr_b = rd_valid ? (grp[LOGN-1:0] + k + len) : '0;
  assign tf_addr   = rd_valid ? tf : '0;

  ntt_wr_delay #(
    .LAT (BU_LAT),
    .W   (2*LOGN + 1)
  ) u_wr_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_valid, rd_addr_a, rd_addr_b}),
    .dout ({wr_valid, wr_addr_a, wr_addr_b})
  );

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sched.sv
`default_nettype none
// tb_ntt_stage_sched: vector table, hand sequences, timeline reference model and
// a golden RAM/butterfly run compared against a software NTT.
module tb_ntt_stage_sched;
  import ntt_pkg::*;

  localparam int N      = 256;
  localparam int LOGN   = 8;
  localparam int BU_LAT = 2;
  localparam int MAXC   = 4096;
  localparam int Q      = 3329;

  logic       clk = 1'b0;
  logic       rst, start, stall;
  logic       busy, done, rd_valid, wr_valid;
  addr_t      rd_addr_a, rd_addr_b, tf_addr, wr_addr_a, wr_addr_b;
  logic [2:0] stage;

  always #5 clk = ~clk;

  ntt_stage_sched #(.N(N), .LOGN(LOGN), .BU_LAT(BU_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .rd_valid(rd_valid),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tf_addr(tf_addr),
    .wr_valid(wr_valid), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .stage(stage)
  );

  typedef struct {
    logic rv; addr_t a; addr_t b; addr_t tf;
    logic wv; addr_t wa; addr_t wb;
    logic done; logic busy; logic [2:0] stage;
  } obs_t;

  typedef struct {
    int c; logic rv; int a; int b; int tf;
    logic wv; int wa; int wb; logic dn; logic bz;
  } vec_t;

  typedef struct { int unsigned va; int unsigned vb; } bu_t;

  obs_t        lg [MAXC];
  obs_t        ex [MAXC];
  bit          stall_pat [MAXC];
  bit          start_pat [MAXC];
  bit          rst_pat   [MAXC];
  int unsigned ram [N];
  int unsigned init_v [N];
  int unsigned ref_v [N];
  int unsigned tw [N];
  bu_t         bq [$];
  vec_t        tv [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cyc;

  task automatic chk(string nm, int c, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, c, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(obs_t o, logic mr, logic mw);
    return {20'h0, o.rv, mr ? o.a : addr_t'(0), mr ? o.b : addr_t'(0),
            mr ? o.tf : addr_t'(0), o.wv, mw ? o.wa : addr_t'(0),
            mw ? o.wb : addr_t'(0), o.done, o.busy};
  endfunction

  function automatic int unsigned mulq(int unsigned x, int unsigned y);
    return int'((longint'(x) * longint'(y)) % Q);
  endfunction

  // Textbook in-place Cooley-Tukey loop with one twiddle per group.
  task automatic load_ram();
    int kk = 0;
    for (int i = 0; i < N; i++) begin
      init_v[i] = $urandom_range(0, Q - 1);
      ram[i]    = init_v[i];
      ref_v[i]  = init_v[i];
    end
    for (int len = N / 2; len >= 1; len = len / 2)
      for (int s = 0; s < N; s += 2 * len) begin
        kk++;
        for (int j = s; j < s + len; j++) begin
          int unsigned t;
          t            = mulq(tw[kk], ref_v[j + len]);
          ref_v[j+len] = (ref_v[j] + Q - t) % Q;
          ref_v[j]     = (ref_v[j] + t) % Q;
        end
      end
  endtask

  task automatic clr_pats();
    for (int c = 0; c < MAXC; c++) begin
      stall_pat[c] = 1'b0; start_pat[c] = 1'b0; rst_pat[c] = 1'b0;
    end
  endtask

  // Expected per-cycle behaviour from the loop nest and the stall pattern.
  task automatic build_model(int s0);
    int c = s0 + 1;
    int tfk = 0;
    int st = 0;
    for (int c2 = 0; c2 < MAXC; c2++) ex[c2] = '{default: '0};
    for (int len = N / 2; len >= 1; len = len / 2) begin
      for (int g = 0; g < N; g += 2 * len) begin
        tfk++;
        for (int j = g; j < g + len; j++) begin
          while (stall_pat[c]) begin
            ex[c].busy = 1'b1; ex[c].stage = 3'(st); c++;
          end
          ex[c].rv = 1'b1; ex[c].a = addr_t'(j); ex[c].b = addr_t'(j + len);
          ex[c].tf = addr_t'(tfk); ex[c].busy = 1'b1; ex[c].stage = 3'(st);
          ex[c+BU_LAT].wv = 1'b1; ex[c+BU_LAT].wa = addr_t'(j);
          ex[c+BU_LAT].wb = addr_t'(j + len);
          c++;
        end
      end
      repeat (BU_LAT) begin
        ex[c].busy = 1'b1; ex[c].stage = 3'(st); c++;
      end
      st++;
    end
    ex[c].done = 1'b1; ex[c].busy = 1'b1; ex[c].stage = 3'(LOGN - 1);
    done_cyc = c;
  endtask

  task automatic bu_step(int c);
    bu_t e;
    if (wr_valid) begin
      if (bq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL bu_queue @cycle %0d: got wr_valid with no butterfly in flight, expected none", c);
      end else begin
        e = bq.pop_front();
        ram[wr_addr_a] = e.va;
        ram[wr_addr_b] = e.vb;
      end
    end
    if (rd_valid) begin
      int unsigned t;
      t = mulq(tw[tf_addr], ram[rd_addr_b]);
      e.va = (ram[rd_addr_a] + t) % Q;
      e.vb = (ram[rd_addr_a] + Q - t) % Q;
      bq.push_back(e);
    end
  endtask

  task automatic run(int ncyc, int reload_c);
    load_ram();
    bq.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      rst = rst_pat[c]; start = start_pat[c]; stall = stall_pat[c];
      @(negedge clk);
      lg[c] = '{rd_valid, rd_addr_a, rd_addr_b, tf_addr, wr_valid,
                wr_addr_a, wr_addr_b, done, busy, stage};
      bu_step(c);
      if (rst_pat[c]) bq.delete();
      if (c == reload_c) load_ram();
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; stall = 1'b0;
  endtask

  task automatic check_model(int from, int to);
    for (int c = from; c < to; c++) begin
      chk("model_cycle", c, pk(lg[c], ex[c].rv, ex[c].wv), pk(ex[c], 1'b1, 1'b1));
      if (ex[c].busy) chk("model_stage", c, 64'(lg[c].stage), 64'(ex[c].stage));
    end
  endtask

  task automatic check_ram();
    for (int i = 0; i < N; i++) chk("ram_vs_sw_ntt", i, 64'(ram[i]), 64'(ref_v[i]));
  endtask

  function automatic int count_done(int from, int to);
    int n = 0;
    for (int c = from; c < to; c++) if (lg[c].done) n++;
    return n;
  endfunction

  initial begin
    obs_t e;
    for (int i = 0; i < N; i++) tw[i] = (i * 1229 + 17) % Q;
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 0, {pk('{rd_valid, rd_addr_a, rd_addr_b, tf_addr, wr_valid,
        wr_addr_a, wr_addr_b, done, busy, stage}, 1'b1, 1'b1), 3'(0)} , 64'(0));
    chk("reset_stage", 0, 64'(stage), 64'(0));
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    // Run 1: no stall, spurious starts at 200 and 1041.
    tv.push_back('{0,    0, 0,   0,   0,   0, 0,   0,   0, 0});
    tv.push_back('{1,    1, 0,   128, 1,   0, 0,   0,   0, 1});
    tv.push_back('{2,    1, 1,   129, 1,   0, 0,   0,   0, 1});
    tv.push_back('{3,    1, 2,   130, 1,   1, 0,   128, 0, 1});
    tv.push_back('{128,  1, 127, 255, 1,   1, 125, 253, 0, 1});
    tv.push_back('{129,  0, 0,   0,   0,   1, 126, 254, 0, 1});
    tv.push_back('{130,  0, 0,   0,   0,   1, 127, 255, 0, 1});
    tv.push_back('{131,  1, 0,   64,  2,   0, 0,   0,   0, 1});
    tv.push_back('{133,  1, 2,   66,  2,   1, 0,   64,  0, 1});
    tv.push_back('{194,  1, 63,  127, 2,   1, 61,  125, 0, 1});
    tv.push_back('{195,  1, 128, 192, 3,   1, 62,  126, 0, 1});
    tv.push_back('{911,  1, 0,   1,   128, 0, 0,   0,   0, 1});
    tv.push_back('{912,  1, 2,   3,   129, 0, 0,   0,   0, 1});
    tv.push_back('{913,  1, 4,   5,   130, 1, 0,   1,   0, 1});
    tv.push_back('{1038, 1, 254, 255, 255, 1, 250, 251, 0, 1});
    tv.push_back('{1040, 0, 0,   0,   0,   1, 254, 255, 0, 1});
    tv.push_back('{1041, 0, 0,   0,   0,   0, 0,   0,   1, 1});
    tv.push_back('{1042, 0, 0,   0,   0,   0, 0,   0,   0, 0});
    tv.push_back('{1045, 0, 0,   0,   0,   0, 0,   0,   0, 0});
    clr_pats();
    start_pat[0] = 1'b1; start_pat[200] = 1'b1; start_pat[1041] = 1'b1;
    build_model(0);
    run(1050, -1);
    foreach (tv[i]) begin
      e = '{tv[i].rv, addr_t'(tv[i].a), addr_t'(tv[i].b), addr_t'(tv[i].tf), tv[i].wv,
            addr_t'(tv[i].wa), addr_t'(tv[i].wb), tv[i].dn, tv[i].bz, 3'(0)};
      chk("vector", tv[i].c, pk(lg[tv[i].c], tv[i].rv, tv[i].wv), pk(e, 1'b1, 1'b1));
    end
    chk("stage_130", 130, 64'(lg[130].stage), 64'(0));
    chk("stage_131", 131, 64'(lg[131].stage), 64'(1));
    chk("stage_911", 911, 64'(lg[911].stage), 64'(7));
    chk("stage_1041", 1041, 64'(lg[1041].stage), 64'(7));
    chk("done_count", 0, 64'(count_done(0, 1050)), 64'(1));
    check_model(0, 1050);
    check_ram();

    // Run 2: stall held high for cycles 5..9.
    clr_pats();
    start_pat[0] = 1'b1;
    for (int c = 5; c <= 9; c++) stall_pat[c] = 1'b1;
    build_model(0);
    run(1055, -1);
    for (int c = 5; c <= 9; c++) chk("stall_no_rd", c, 64'(lg[c].rv), 64'(0));
    chk("after_stall_10", 10, {lg[10].rv, lg[10].a, lg[10].b}, {1'b1, 8'd4, 8'd132});
    chk("after_stall_11", 11, {lg[11].rv, lg[11].a, lg[11].b}, {1'b1, 8'd5, 8'd133});
    for (int c = 7; c <= 11; c++) chk("stall_wr_gap", c, 64'(lg[c].wv), 64'(0));
    chk("wr_after_gap", 12, {lg[12].wv, lg[12].wa, lg[12].wb}, {1'b1, 8'd4, 8'd132});
    chk("done_1046", 1046, 64'(lg[1046].done), 64'(1));
    chk("done_count_stall", 0, 64'(count_done(0, 1055)), 64'(1));
    check_model(0, 1055);
    check_ram();

    // Run 3: random stall at roughly 30%.
    clr_pats();
    start_pat[0] = 1'b1;
    for (int c = 1; c < MAXC; c++) stall_pat[c] = ($urandom_range(0, 99) < 30);
    build_model(0);
    if (done_cyc + 5 > MAXC) begin
      $display("FAIL rand_budget: got done at %0d, expected below %0d", done_cyc, MAXC - 5);
      n_cmp++; n_fail++;
      done_cyc = MAXC - 5;
    end
    run(done_cyc + 5, -1);
    check_model(0, done_cyc + 5);
    check_ram();

    // Run 4: reset at 500 aborts, fresh start at 510.
    clr_pats();
    start_pat[0] = 1'b1; rst_pat[500] = 1'b1; start_pat[510] = 1'b1;
    build_model(510);
    run(1560, 505);
    for (int c = 501; c <= 510; c++)
      chk("post_reset_vals", c, {pk(lg[c], 1'b1, 1'b1), lg[c].stage} , 64'(0));
    chk("restart_511", 511, {lg[511].rv, lg[511].a, lg[511].b, lg[511].tf},
        {1'b1, 8'd0, 8'd128, 8'd1});
    chk("done_1551", 1551, 64'(lg[1551].done), 64'(1));
    chk("done_count_rst", 501, 64'(count_done(501, 1560)), 64'(1));
    check_model(501, 1560);
    check_ram();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_stage_sched.md
Name: ntt_stage_sched

Overview:
Sequencer for an in-place radix-2 Cooley-Tukey NTT with a separate dual-port coefficient RAM and a fixed-latency pipelined butterfly unit (BU).
- Per cycle, issues one butterfly: read address pair, twiddle-ROM address, and matching write-back address pair BU_LAT cycles later.
- Drains the BU between stages so no stage reads data the previous stage has not yet written.
- Sits between the top-level load/unload control and the RAM/BU/twiddle ROM; holds no coefficient data.

Parameters:
N, 256, transform length (power of two, >=4)
LOGN, 8, log2(N); also address width
BU_LAT, 2, butterfly latency in cycles from read issue to write-back (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  begin transform; sampled only in IDLE
stall  input  1  suppress issue this cycle (RAM port conflict / backpressure)
busy  output  1  high from the cycle after start is accepted until done pulses
done  output  1  one-cycle pulse after the final write-back
rd_valid  output  1  read pair + twiddle valid this cycle
rd_addr_a  output  LOGN  address j
rd_addr_b  output  LOGN  address j+len
tf_addr  output  LOGN  twiddle ROM address, aligned with rd_valid
wr_valid  output  1  write-back pair valid (rd_valid delayed BU_LAT)
wr_addr_a  output  LOGN  rd_addr_a delayed BU_LAT
wr_addr_b  output  LOGN  rd_addr_b delayed BU_LAT
stage  output  $clog2(LOGN)  current stage index 0..LOGN-1

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset values: busy=0, done=0, rd_valid=0, wr_valid=0, all address outputs 0, stage=0, delay line cleared, FSM in IDLE.
- Reset mid-transform aborts immediately. No wr_valid is asserted after the reset cycle.
- FSM states and transitions:
  - IDLE -> ISSUE on start=1.
  - ISSUE -> DRAIN after the last pair of the stage is issued.
  - DRAIN -> ISSUE (next stage) or -> DONE after the stage's last write-back.
  - DONE -> IDLE after one cycle.
- Loop order:
  - len = N/2 at stage 0, halving each stage down to 1.
  - Groups: start = 0, 2len, 4len, ... < N.
  - Within a group, j = start .. start+len-1; issued pair is (j, j+len).
- tf_addr behaviour:
  - Starts at 1 at the first issue of stage 0.
  - Increments by 1 at each group boundary, across stages; never resets between stages.
  - Final group uses tf_addr = N-1.
- Issue rate: one pair per cycle when in ISSUE and stall=0.
  - With stall=1: rd_valid=0 and the j/group/tf counters hold.
  - The delay line always advances; in-flight butterflies complete regardless of stall.
- Stall has no effect in DRAIN, DONE or IDLE.
- DRAIN: lasts BU_LAT cycles, so the last write of stage s occurs in the final DRAIN cycle. The first issue of stage s+1 is the following cycle.
- Timing with no stalls, start sampled at cycle 0:
  - First rd_valid at cycle 1.
  - Each stage occupies N/2 + BU_LAT cycles.
  - done pulses at cycle 1 + LOGN*(N/2+BU_LAT); for the defaults this is cycle 1041.
  - Each stall cycle adds exactly one cycle.
- start while busy is ignored. start asserted in the same cycle as done is ignored; it is accepted in the following IDLE cycle.
- stage updates on the first cycle of the next stage's ISSUE and holds through DONE.
- Counter widths: j, start and group-boundary sums are LOGN+1 bits internally to detect start+2len = N without wrap. Address outputs are the low LOGN bits.

Decomposition:
- Package ntt_pkg holds:
  - N, LOGN, BU_LAT defaults
  - addr_t (logic [LOGN-1:0])
  - FSM state enum: IDLE, ISSUE, DRAIN, DONE
- One sub-module, ntt_wr_delay: a BU_LAT-deep shift register carrying {valid, addr_a, addr_b}, cleared on rst.
- The FSM and counters stay in ntt_stage_sched.

Test Plan:
- Start from IDLE, no stall -> stage 0 issues (0,128,tf1),(1,129,tf1)..(127,255,tf1) on cycles 1..128; wr_valid on cycles 3..130 with identical pairs; stage 1 first issue at cycle 131.
- Stage 1 group boundary -> (63,127,tf2) followed by (128,192,tf3). Last stage -> (0,1,tf128),(2,3,tf129)..(254,255,tf255). done pulses once at cycle 1041; busy is low the next cycle.
- stall high for cycles 5..9 -> no rd_valid in those cycles; pairs (4,132) then (5,133) are consecutive issues; wr_valid gaps mirror the stall gaps exactly; done at cycle 1046.
- start pulsed at cycles 200 and 1041 during a transform -> ignored; exactly one done pulse, at cycle 1041; no restart.
- rst at cycle 500, then start at cycle 510 -> outputs at reset values from cycle 501; no wr_valid after cycle 500; fresh transform begins at (0,128,tf1) on cycle 511; done at cycle 1551.
- Golden-model check: a bench RAM + reference BU driven by the outputs, random stall at 30% -> final RAM equals a software NTT of the random input vector.
